// File: rtl/mux_4to1.sv
// Registered 4-to-1 path selector: sout is the path chosen by sel, 1 cycle later.
// No flow control: the output register updates on every edge; synchronous reset clears it.
module mux_4to1 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] p1,
  input  logic [WIDTH-1:0] p2,
  input  logic [WIDTH-1:0] p3,
  output logic [WIDTH-1:0] sout
);

  logic [WIDTH-1:0] sout_d;
  logic [WIDTH-1:0] sout_q;

  always_comb begin
    sout_d = p0;
    case (sel)
      2'd0: sout_d = p0;
      2'd1: sout_d = p1;
      2'd2: sout_d = p2;
      2'd3: sout_d = p3;
    endcase
  end

  // Reset wins over data; no enable, so the register reloads every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sout_q <= '0;
    end else begin
      sout_q <= sout_d;
    end
  end

  assign sout = sout_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1: directed vectors push hand-computed results into a queue,
// a monitor pops and compares one entry per clock after each edge.
module tb_mux_4to1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic [1:0] p0, p1, p2, p3;
  logic [1:0] sout;

  logic       rst8;
  logic [1:0] sel8;
  logic [7:0] w0, w1, w2, w3;
  logic [7:0] sout8;

  logic [1:0] exp_q2[$];
  logic [7:0] exp_q8[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         vec2     = 0;
  int         vec8     = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(2)) dut_narrow (
    .clk (clk), .rst (rst), .sel (sel),
    .p0  (p0),  .p1  (p1),  .p2  (p2), .p3 (p3),
    .sout(sout)
  );

  mux_4to1 #(.WIDTH(8)) dut_wide (
    .clk (clk), .rst (rst8), .sel (sel8),
    .p0  (w0),  .p1  (w1),   .p2  (w2), .p3 (w3),
    .sout(sout8)
  );

  task automatic drv2(input logic r, input logic [1:0] s,
                      input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [1:0] d,
                      input logic [1:0] exp);
    @(negedge clk);
    rst = r; sel = s; p0 = a; p1 = b; p2 = c; p3 = d;
    exp_q2.push_back(exp);
  endtask

  task automatic drv8(input logic r, input logic [1:0] s, input logic [7:0] exp);
    @(negedge clk);
    rst8 = r; sel8 = s;
    exp_q8.push_back(exp);
  endtask

  // Monitor: each queued entry corresponds to exactly one upcoming edge.
  always @(posedge clk) begin
    #1;
    if (exp_q2.size() > 0) begin
      logic [1:0] e2;
      e2 = exp_q2.pop_front();
      n_checks++;
      if (sout !== e2) begin
        n_fail++;
        $display("FAIL narrow_sout vec %0d: got %b expected %b", vec2, sout, e2);
      end
      vec2++;
    end
    if (exp_q8.size() > 0) begin
      logic [7:0] e8;
      e8 = exp_q8.pop_front();
      n_checks++;
      if (sout8 !== e8) begin
        n_fail++;
        $display("FAIL wide_sout vec %0d: got %h expected %h", vec8, sout8, e8);
      end
      vec8++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 2'd0; p0 = 2'd0; p1 = 2'd0; p2 = 2'd0; p3 = 2'd0;
    rst8 = 1'b1; sel8 = 2'd0;
    w0 = 8'h00; w1 = 8'h5A; w2 = 8'hA5; w3 = 8'hFF;

    // Reset held two cycles with sel=3, p3=11, then released
    drv2(1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'b00);
    drv2(1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'b00);
    drv2(0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'b11);

    // Constant paths, sel sequence 0,3,1,0,2
    drv2(0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'b00);
    drv2(0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'b11);
    drv2(0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'b01);
    drv2(0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'b00);
    drv2(0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'b10);

    // Unselected paths toggling, sel=2 with p2=10
    drv2(0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'b10);
    drv2(0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'b10);
    drv2(0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2, 2'b10);
    drv2(0, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1, 2'b10);

    // Live data on the selected path, sel=1
    drv2(0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2, 2'b00);
    drv2(0, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'b01);
    drv2(0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd2, 2'b10);
    drv2(0, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'b11);

    // Reset mid-stream while sel=3, then selections resume
    drv2(0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'b00);
    drv2(1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'b00);
    drv2(0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'b01);
    drv2(0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'b00);
    drv2(0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'b10);

    // sel and newly selected path change on the same edge
    drv2(0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'b01);
    drv2(0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd2, 2'b10);
    drv2(0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'b11);
    drv2(0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'b11);

    // Wide instance: reset, then sweep sel up and down
    drv8(1, 2'd3, 8'h00);
    drv8(0, 2'd0, 8'h00);
    drv8(0, 2'd1, 8'h5A);
    drv8(0, 2'd2, 8'hA5);
    drv8(0, 2'd3, 8'hFF);
    drv8(0, 2'd2, 8'hA5);
    drv8(0, 2'd0, 8'h00);
    drv8(0, 2'd3, 8'hFF);
    drv8(0, 2'd1, 8'h5A);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q2.size() != 0 || exp_q8.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", exp_q2.size(), exp_q8.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_4to1.md
# mux_4to1

Registered 4-to-1 selector that forwards one of four equal-width data paths to a single output based on a 2-bit select code. It is a leaf datapath block. Upstream logic drives the select and the four path values, and downstream logic consumes `sout` one clock after the selection is presented. In the standard configuration the four paths are tied to constants 0, 1, 2 and 3, so `sout` echoes `sel` with one cycle of latency.

## Interface
- `WIDTH`, default 2: bit width of each data path and of `sout`; legal range ≥ 1.
- `clk`  input  1  rising-edge clock; the only clock of the block.
- `rst`  input  1  reset, synchronous, active-high.
- `sel`  input  2  path select code: 0→`p0`, 1→`p1`, 2→`p2`, 3→`p3`.
- `p0`  input  WIDTH  data path 0.
- `p1`  input  WIDTH  data path 1.
- `p2`  input  WIDTH  data path 2.
- `p3`  input  WIDTH  data path 3.
- `sout`  output  WIDTH  selected path, registered.

## Operation
- Combinational select stage:
  - `next = (sel==0) ? p0 : (sel==1) ? p1 : (sel==2) ? p2 : p3`.
  - Implement as a full case over all four codes with no latch.
- Output register:
  - Each rising `clk` edge with `rst`=0: `sout <= next`.
  - Each rising `clk` edge with `rst`=1: `sout <= 0` (all WIDTH bits).
- Reset has priority over data; `sel` and `p*` are ignored while `rst`=1.
- No enable and no hold. The register updates on every non-reset edge, even when the selected value is unchanged.
- No arithmetic or width conversion. Data passes bit-exact. Paths and output are the same width, with no truncation or extension.
- `sel` is always one of four legal codes, so there is no default or error output.
- Data values are unconstrained; any WIDTH-bit pattern on any path is forwarded unchanged.

## Timing
- Latency is exactly 1 cycle: `sout` after edge k equals the path chosen by `sel` sampled at edge k, using `p*` values sampled at edge k.
- `sout` is registered, with no combinational path from any input to `sout`.
- Reset value:
  - `sout` = 0 after the first rising edge with `rst`=1.
  - Before the first reset edge, `sout` is undefined.
- Reset mid-operation: `sout` is 0 after the next edge. On the first edge after `rst` falls, `sout` takes the path selected at that edge.
- A simultaneous change of `sel` and the selected path at the same edge: `sout` reflects the new `sel` together with the new path value.
- A path change on an unselected input has no effect on `sout`.
- Back-to-back `sel` changes every cycle are fully supported. Each code appears on `sout` exactly one cycle later, with no skipped or repeated values.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `sel`=3 and `p3`=11 → `sout`=00 after each reset edge; release → `sout`=11 one edge later.
- Constant paths: tie `p0`=00, `p1`=01, `p2`=10, `p3`=11; drive `sel` sequence 0,3,1,0,2, each held for one cycle → `sout` sequence 00,11,01,00,10, each one cycle after its `sel`.
- Path independence: `sel`=2 with `p2`=10 fixed, toggle `p0`, `p1` and `p3` each cycle → `sout` stays 10.
- Live data tracking: `sel`=1, `p1` stepping 00,01,10,11 → `sout` follows with 1-cycle lag.
- Reset mid-stream: during the `sel` sequence above, assert `rst` for 1 cycle while `sel`=3 → `sout`=00 for that cycle, then resumes correct selections.
- Width: `WIDTH`=8 with `p0`=0x00, `p1`=0x5A, `p2`=0xA5, `p3`=0xFF; sweep `sel` 0..3 → `sout` = 0x00, 0x5A, 0xA5, 0xFF, each one cycle later.
